// File: rtl/dcache_pkg.sv
// dcache_pkg: shared encodings, FSM states and byte-lane helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam logic LS_LOAD  = 1'b0;
    localparam logic LS_STORE = 1'b1;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, MISS_RD, IO_RD, WR_THRU} state_t;

    function automatic logic [3:0] be_of(input logic [1:0] lane, input logic [1:0] len);
        return len == LEN_BYTE ? 4'b0001 << lane : len == LEN_HALF ? 4'b0011 << lane : 4'b1111;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [1:0] len);
        logic [31:0] s;
        s = word >> {lane, 3'b000};
        return len == LEN_BYTE ? {24'b0, s[7:0]} : len == LEN_HALF ? {16'b0, s[15:0]} : s;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data line storage with async read and a byte-enabled write port.
module dcache_array #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    input  logic               we,
    input  logic [INDEX_W-1:0] w_idx,
    input  logic [TAG_W-1:0]   w_tag,
    input  logic [31:0]        w_data,
    input  logic [3:0]         w_be
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

    always_ff @(posedge clk) begin
        if (rst)
            valid <= '0;
        else if (we)
            valid[w_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[w_idx] <= w_tag;
            for (int i = 0; i < 4; i++)
                if (w_be[i])
                    data[w_idx][8*i +: 8] <= w_data[8*i +: 8];
        end
    end

endmodule

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped write-through, no-write-allocate data cache between SLB and MC.
// Addresses at or above IO_BASE bypass the array.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter int                INDEX_W = 6,
    parameter int                NICK_W  = 4,
    parameter logic [ADDR_W-1:0] IO_BASE = 32'h0003_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_ls,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_len,
    input  logic [NICK_W-1:0] req_tag,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic [NICK_W-1:0] rsp_tag,
    output logic              mc_en,
    output logic              mc_ls,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [31:0]       mc_data,
    output logic [1:0]        mc_len,
    input  logic              mc_done,
    input  logic [31:0]       mc_rdata
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   cur_addr;
    logic [1:0]          cur_len;
    logic [NICK_W-1:0]   cur_tag;
    logic                killed;

    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [31:0]         rd_data;
    logic                we;
    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [31:0]         w_data;
    logic [3:0]          w_be;

    logic accept, cacheable, hit;

    assign req_ready = rdy & ~rst & ~flush & (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign cacheable = req_addr < IO_BASE;
    assign hit       = rd_valid & (rd_tag == req_addr[ADDR_W-1:INDEX_W+2]) & cacheable;

    dcache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_addr[INDEX_W+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (we & rdy & ~rst),
        .w_idx    (w_idx),
        .w_tag    (w_tag),
        .w_data   (w_data),
        .w_be     (w_be)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (rdy)
            state <= state_nx;
    end

    // Array writes come from a store hit at accept or a line fill on miss completion.
    always_comb begin
        state_nx = state;
        we       = 1'b0;
        w_idx    = req_addr[INDEX_W+1:2];
        w_tag    = req_addr[ADDR_W-1:INDEX_W+2];
        w_data   = req_data << {req_addr[1:0], 3'b000};
        w_be     = be_of(req_addr[1:0], req_len);
        if (state == IDLE && accept) begin
            state_nx = req_ls ? WR_THRU : !cacheable ? IO_RD : hit ? IDLE : MISS_RD;
            we       = req_ls & hit;
        end else if (state != IDLE && mc_done) begin
            state_nx = IDLE;
            we       = state == MISS_RD;
            w_idx    = cur_addr[INDEX_W+1:2];
            w_tag    = cur_addr[ADDR_W-1:INDEX_W+2];
            w_data   = mc_rdata;
            w_be     = 4'hF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            mc_en     <= 1'b0;
            mc_ls     <= 1'b0;
            mc_addr   <= '0;
            mc_data   <= '0;
            mc_len    <= '0;
            cur_addr  <= '0;
            cur_len   <= '0;
            cur_tag   <= '0;
            killed    <= 1'b0;
        end else if (rdy) begin
            rsp_valid <= 1'b0;
            if (state == IDLE && accept) begin
                cur_addr <= req_addr;
                cur_len  <= req_len;
                cur_tag  <= req_tag;
                killed   <= 1'b0;
                if (!req_ls && hit) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= extract(rd_data, req_addr[1:0], req_len);
                    rsp_tag   <= req_tag;
                end else begin
                    mc_en   <= 1'b1;
                    mc_ls   <= req_ls;
                    mc_addr <= (!req_ls && cacheable) ? {req_addr[ADDR_W-1:2], 2'b00} : req_addr;
                    mc_len  <= (!req_ls && cacheable) ? LEN_WORD : req_len;
                    mc_data <= req_ls ? req_data : '0;
                end
            end else if (state != IDLE) begin
                // A flush at any point of a pending load cancels its response, not its fill.
                killed <= killed | flush;
                if (mc_done) begin
                    mc_en     <= 1'b0;
                    rsp_valid <= (state == WR_THRU) | ~(killed | flush);
                    rsp_tag   <= cur_tag;
                    rsp_data  <= state == MISS_RD ? extract(mc_rdata, cur_addr[1:0], cur_len) :
                                 state == IO_RD   ? extract(mc_rdata, 2'b00, cur_len) : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed vector table for dcache_dm plus hand-written flush, stall and reset sequences.
module tb_dcache_dm;
    import dcache_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0;
    logic        req_valid = 1'b0, req_ls = 1'b0;
    logic [31:0] req_addr = '0, req_data = '0;
    logic [1:0]  req_len = '0;
    logic [3:0]  req_tag = '0;
    logic        req_ready, rsp_valid, mc_en, mc_ls;
    logic [31:0] rsp_data, mc_addr, mc_data;
    logic [3:0]  rsp_tag;
    logic [1:0]  mc_len;
    logic        mc_done = 1'b0;
    logic [31:0] mc_rdata = '0;

    always #5 clk = ~clk;

    dcache_dm dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_ls(req_ls),
        .req_addr(req_addr), .req_data(req_data), .req_len(req_len), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .mc_en(mc_en), .mc_ls(mc_ls), .mc_addr(mc_addr), .mc_data(mc_data), .mc_len(mc_len),
        .mc_done(mc_done), .mc_rdata(mc_rdata)
    );

    typedef struct {
        logic        ls;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  len;
        logic [3:0]  tag;
        logic        mc;
        logic [31:0] mc_addr;
        logic [1:0]  mc_len;
        logic [31:0] mc_data;
        logic [31:0] rdata;
        logic [31:0] rsp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0, n_cmp = 0, n_err = 0;

    function automatic vec_t mk(input logic ls, input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] len, input logic [3:0] tag, input logic mc,
                                input logic [31:0] ma, input logic [1:0] ml, input logic [31:0] md,
                                input logic [31:0] rdata, input logic [31:0] rsp);
        vec_t v;
        v.ls = ls; v.addr = addr; v.data = data; v.len = len; v.tag = tag; v.mc = mc;
        v.mc_addr = ma; v.mc_len = ml; v.mc_data = md; v.rdata = rdata; v.rsp = rsp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_done(input logic [31:0] d);
        @(negedge clk);
        mc_done = 1'b1;
        mc_rdata = d;
        @(posedge clk);
        #1;
        mc_done = 1'b0;
    endtask

    task automatic issue(input logic ls, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] len, input logic [3:0] tag);
        @(negedge clk);
        req_valid = 1'b1; req_ls = ls; req_addr = addr; req_data = data; req_len = len; req_tag = tag;
        #1;
        chk($sformatf("req_ready[t%0d]", tag), {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        n_vec++;
        issue(v.ls, v.addr, v.data, v.len, v.tag);
        if (v.mc) begin
            chk($sformatf("mc_en[t%0d]", v.tag), {31'b0, mc_en}, 32'd1);
            chk($sformatf("mc_ls[t%0d]", v.tag), {31'b0, mc_ls}, {31'b0, v.ls});
            chk($sformatf("mc_addr[t%0d]", v.tag), mc_addr, v.mc_addr);
            chk($sformatf("mc_len[t%0d]", v.tag), {30'b0, mc_len}, {30'b0, v.mc_len});
            chk($sformatf("mc_data[t%0d]", v.tag), mc_data, v.mc_data);
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("rsp_early[t%0d]", v.tag), {31'b0, rsp_valid}, 32'd0);
            chk($sformatf("mc_hold[t%0d]", v.tag), mc_addr, v.mc_addr);
            drive_done(v.rdata);
        end
        chk($sformatf("rsp_valid[t%0d]", v.tag), {31'b0, rsp_valid}, 32'd1);
        chk($sformatf("rsp_data[t%0d]", v.tag), rsp_data, v.rsp);
        chk($sformatf("rsp_tag[t%0d]", v.tag), {28'b0, rsp_tag}, {28'b0, v.tag});
        chk($sformatf("mc_idle[t%0d]", v.tag), {31'b0, mc_en}, 32'd0);
    endtask

    initial begin
        //                 ls addr          data          len       tag mc mc_addr       mc_len    mc_data       rdata         rsp
        vecs.push_back(mk(0, 32'h0000_1004, 32'h0,        LEN_WORD, 1,  1, 32'h0000_1004, LEN_WORD, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 32'h0000_1005, 32'h0,        LEN_BYTE, 2,  0, 32'h0,         LEN_BYTE, 32'h0,        32'h0,         32'h0000_00BE));
        vecs.push_back(mk(1, 32'h0000_1006, 32'h55,       LEN_BYTE, 3,  1, 32'h0000_1006, LEN_BYTE, 32'h55,       32'h0,         32'h0));
        vecs.push_back(mk(0, 32'h0000_1004, 32'h0,        LEN_WORD, 4,  0, 32'h0,         LEN_BYTE, 32'h0,        32'h0,         32'hDE55_BEEF));
        vecs.push_back(mk(0, 32'h0000_1006, 32'h0,        LEN_HALF, 5,  0, 32'h0,         LEN_BYTE, 32'h0,        32'h0,         32'h0000_DE55));
        vecs.push_back(mk(0, 32'h0000_1104, 32'h0,        LEN_WORD, 6,  1, 32'h0000_1104, LEN_WORD, 32'h0,        32'h1234_5678, 32'h1234_5678));
        vecs.push_back(mk(0, 32'h0000_1004, 32'h0,        LEN_WORD, 7,  1, 32'h0000_1004, LEN_WORD, 32'h0,        32'hCAFE_F00D, 32'hCAFE_F00D));
        vecs.push_back(mk(0, 32'h0003_0000, 32'h0,        LEN_BYTE, 8,  1, 32'h0003_0000, LEN_BYTE, 32'h0,        32'hAABB_CCDD, 32'h0000_00DD));
        vecs.push_back(mk(0, 32'h0003_0000, 32'h0,        LEN_BYTE, 9,  1, 32'h0003_0000, LEN_BYTE, 32'h0,        32'h1122_3344, 32'h0000_0044));
        vecs.push_back(mk(1, 32'h0000_2000, 32'h0BAD_F00D, LEN_WORD, 10, 1, 32'h0000_2000, LEN_WORD, 32'h0BAD_F00D, 32'h0,        32'h0));
        vecs.push_back(mk(0, 32'h0000_2000, 32'h0,        LEN_WORD, 11, 1, 32'h0000_2000, LEN_WORD, 32'h0,        32'h0BAD_F00D, 32'h0BAD_F00D));
        vecs.push_back(mk(0, 32'h0000_1007, 32'h0,        LEN_BYTE, 12, 0, 32'h0,         LEN_BYTE, 32'h0,        32'h0,         32'h0000_00CA));
        vecs.push_back(mk(0, 32'h0000_1002, 32'h0,        LEN_HALF, 13, 1, 32'h0000_1000, LEN_WORD, 32'h0,        32'h89AB_CDEF, 32'h0000_89AB));
        vecs.push_back(mk(1, 32'h0003_0001, 32'h7F,       LEN_BYTE, 14, 1, 32'h0003_0001, LEN_BYTE, 32'h7F,       32'h0,         32'h0));
        vecs.push_back(mk(0, 32'h0000_1000, 32'h0,        LEN_BYTE, 15, 0, 32'h0,         LEN_BYTE, 32'h0,        32'h0,         32'h0000_00EF));
        vecs.push_back(mk(1, 32'h0000_1000, 32'hA5A5,     LEN_HALF, 1,  1, 32'h0000_1000, LEN_HALF, 32'hA5A5,     32'h0,         32'h0));
        vecs.push_back(mk(0, 32'h0000_1000, 32'h0,        LEN_WORD, 2,  0, 32'h0,         LEN_BYTE, 32'h0,        32'h0,         32'h89AB_A5A5));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        chk("reset_mc_en", {31'b0, mc_en}, 32'd0);
        chk("reset_mc_addr", mc_addr, 32'd0);
        chk("reset_mc_data", mc_data, 32'd0);
        chk("reset_mc_len", {30'b0, mc_len}, 32'd0);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_tag", {28'b0, rsp_tag}, 32'd0);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // flush in IDLE blocks acceptance
        n_vec++;
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_ls = 1'b0; req_addr = 32'h1000; req_len = LEN_WORD; req_tag = 3;
        #1;
        chk("flush_idle_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_idle_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("flush_idle_mc", {31'b0, mc_en}, 32'd0);

        // flush during MISS_RD: response suppressed, line still filled
        n_vec++;
        issue(LS_LOAD, 32'h0000_3000, 32'h0, LEN_WORD, 4);
        chk("flush_miss_mc", {31'b0, mc_en}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive_done(32'h600D_CAFE);
        chk("flush_miss_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("flush_miss_mc_off", {31'b0, mc_en}, 32'd0);
        @(negedge clk);
        chk("flush_miss_rsp2", {31'b0, rsp_valid}, 32'd0);
        run_vec(mk(0, 32'h0000_3000, 32'h0, LEN_WORD, 5, 0, 32'h0, LEN_BYTE, 32'h0, 32'h0, 32'h600D_CAFE));

        // rdy low mid-miss freezes everything, including a stray mc_done
        n_vec++;
        issue(LS_LOAD, 32'h0000_1404, 32'h0, LEN_WORD, 6);
        @(negedge clk);
        rdy = 1'b0;
        mc_done = 1'b1;
        mc_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", {31'b0, req_ready}, 32'd0);
            chk("stall_mc_en", {31'b0, mc_en}, 32'd1);
            chk("stall_mc_addr", mc_addr, 32'h0000_1404);
            chk("stall_mc_len", {30'b0, mc_len}, {30'b0, LEN_WORD});
            chk("stall_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        mc_done = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        chk("stall_resume_mc_en", {31'b0, mc_en}, 32'd1);
        chk("stall_resume_rsp", {31'b0, rsp_valid}, 32'd0);
        drive_done(32'h1404_1404);
        chk("stall_done_rsp", {31'b0, rsp_valid}, 32'd1);
        chk("stall_done_data", rsp_data, 32'h1404_1404);
        chk("stall_done_tag", {28'b0, rsp_tag}, 32'd6);

        // reset during WR_THRU returns to IDLE with every line invalid
        n_vec++;
        issue(LS_STORE, 32'h0000_1404, 32'h77, LEN_WORD, 7);
        chk("wr_mc_ls", {31'b0, mc_ls}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_wr_mc_en", {31'b0, mc_en}, 32'd0);
        chk("rst_wr_mc_ls", {31'b0, mc_ls}, 32'd0);
        chk("rst_wr_mc_addr", mc_addr, 32'd0);
        chk("rst_wr_mc_data", mc_data, 32'd0);
        chk("rst_wr_ready", {31'b0, req_ready}, 32'd1);
        drive_done(32'hFFFF_FFFF);
        chk("idle_done_ignored", {31'b0, rsp_valid}, 32'd0);
        run_vec(mk(0, 32'h0000_1404, 32'h0, LEN_WORD, 8, 1, 32'h0000_1404, LEN_WORD, 32'h0, 32'h0000_0077, 32'h0000_0077));
        run_vec(mk(0, 32'h0000_3000, 32'h0, LEN_WORD, 9, 1, 32'h0000_3000, LEN_WORD, 32'h0, 32'h600D_CAFE, 32'h600D_CAFE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
Direct-mapped, write-through, no-write-allocate data cache between the store/load buffer (SLB) and the memory controller (MC).
- Replaces the single-slot pass-through with a tagged line array: load hits return in one cycle; misses fetch a word from MC and fill the line.
- Addresses at or above IO_BASE bypass the array and are never cached.
- Supports speculative-load cancel (flush) and the global rdy stall.

Parameters:
ADDR_W, 32, address width
INDEX_W, 6, log2 of line count (line = one 32-bit word)
NICK_W, 4, SLB request tag width
IO_BASE, 32'h0003_0000, first uncached address

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rdy  in  1  global enable; 0 freezes all state
flush  in  1  misprediction; cancel pending load response
req_valid  in  1  SLB request present
req_ready  out  1  request accepted this cycle when high with req_valid
req_ls  in  1  0 = load, 1 = store
req_addr  in  ADDR_W  byte address, naturally aligned
req_data  in  32  store data, low-aligned
req_len  in  2  0 = byte, 1 = half, 2 = word
req_tag  in  NICK_W  SLB nick
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  32  load result, zero-extended; 0 for stores
rsp_tag  out  NICK_W  nick of completed request
mc_en  out  1  MC request
mc_ls  out  1  0 = read, 1 = write
mc_addr  out  ADDR_W  MC address
mc_data  out  32  MC write data
mc_len  out  2  same encoding as req_len
mc_done  in  1  MC completion pulse
mc_rdata  in  32  MC read data, valid with mc_done

Behaviour:
- Reset:
  - state = IDLE; all valid bits cleared.
  - mc_en = 0, mc_ls = 0, mc_addr = 0, mc_data = 0, mc_len = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_tag = 0.
  - A reset mid-transaction abandons it; MC is reset in the same cycle.
- rdy = 0: no register updates; req_ready = 0; outputs hold.
- req_ready is combinational: rdy & ~rst & ~flush & (state == IDLE).
- Address fields: index = addr[INDEX_W+1:2]; tag = addr[ADDR_W-1:INDEX_W+2]; lane = addr[1:0].
- Lookup: hit = valid[index] & (tag match) & (addr < IO_BASE).
- States:
  - IDLE:
    - Load hit: rsp_valid = 1 next cycle, rsp_data = (line >> 8*lane) masked to len. Stays IDLE; back-to-back hits sustain one per cycle.
    - Load miss (cacheable): mc read, addr & ~3, len = word -> MISS_RD.
    - IO load: mc read, exact addr and len -> IO_RD.
    - Store: mc write, exact addr/len/data -> WR_THRU. If it hits, merge the byte-enabled data into the line in the accept cycle. A store miss does not allocate.
  - MISS_RD: on mc_done, write line = mc_rdata, set valid and tag, respond with the extracted bytes -> IDLE.
  - IO_RD: on mc_done, respond with mc_rdata masked to len -> IDLE.
  - WR_THRU: on mc_done, rsp_valid = 1, rsp_data = 0 -> IDLE.
- MC handshake:
  - mc_en and all mc_* fields are set in the accept cycle and held stable until the cycle mc_done is sampled.
  - mc_en = 0 from the following cycle.
  - mc_done outside MISS_RD, IO_RD or WR_THRU is ignored.
- Flush:
  - Asserted in MISS_RD or IO_RD: the transaction still completes and MISS_RD still fills the line; rsp_valid is suppressed.
  - Stores (already committed) are unaffected and still respond.
  - A hit response already registered in the flush cycle is still presented; the SLB discards it.
- Eviction: a miss to an occupied index overwrites that line unconditionally.
- Unaligned requests are out of contract.

Decomposition:
- Shared package dcache_pkg holds:
  - LS_LOAD/LS_STORE
  - LEN_BYTE/LEN_HALF/LEN_WORD
  - the state enum (IDLE, MISS_RD, IO_RD, WR_THRU)
  - the byte-enable and extract helper functions
- Sub-module dcache_array holds the valid/tag/data storage: 1 asynchronous read port, 1 write port with 4-bit byte enable and a valid-clear-all on reset.

Test Plan:
- Cold load word 0x1004, MC returns 0xDEADBEEF -> one mc read (addr 0x1004, len word); rsp_data 0xDEADBEEF with matching tag, one cycle after mc_done.
- Then load byte 0x1005 -> rsp_valid the next cycle, rsp_data 0x000000BE, mc_en stays 0.
- Store byte 0x55 to 0x1006 -> mc write (addr 0x1006, len byte, data 0x55); rsp on mc_done. A following load word 0x1004 hits with 0xDE55BEEF.
- Load 0x1104 (same index, different tag) -> miss and refill. A subsequent load of 0x1004 misses again.
- IO load byte 0x30000 twice -> two mc reads with len byte; no fill; both respond.
- Flush during MISS_RD -> no rsp_valid, but a later load of the same address hits.
- rdy held low for 3 cycles mid-miss -> mc_* fields stable and no state change.
- rst during WR_THRU -> IDLE with all lines invalid.
